// File: rtl/result_unloader_if.sv
`default_nettype none
// ============================================================================
//  Module      : result_unloader_if
//  Description : Bundle of core-side and host-side signals of the result
//                unloader. The slave modport is the unloader's view; the
//                master modport is the view of whoever drives the core
//                result and plays the host.
//  Signals     : result/result_valid  - signed word and capture pulse from core
//                out_ack              - host acknowledge (asynchronous to clk)
//                ovf_clr              - clears the sticky overflow flag
//                out_pins/out_valid   - byte lane and its valid towards host
//                busy/done/overflow   - transfer status back to the core side
//  Revision    : 1.0 - initial release
// ============================================================================
interface result_unloader_if #(
    parameter int NUM_BYTES = 4
);
    localparam int RESULT_W = 8 * NUM_BYTES;

    logic [RESULT_W-1:0] result;
    logic                result_valid;
    logic                out_ack;
    logic                ovf_clr;
    logic [7:0]          out_pins;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic                overflow;

    modport slave (
        input  result, result_valid, out_ack, ovf_clr,
        output out_pins, out_valid, busy, done, overflow
    );

    modport master (
        output result, result_valid, out_ack, ovf_clr,
        input  out_pins, out_valid, busy, done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/result_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : result_unloader
//  Description : Captures a signed result word from the calculation core and
//                sends it to an external host one byte at a time, MSB first,
//                using a four-phase valid/ack handshake on 8 output pins.
//                A result arriving while a word is in flight is dropped and
//                recorded in a sticky overflow flag.
//  Ports       : clk     - system clock, rising edge
//                rst_n   - asynchronous active-low reset
//                bus_if  - slave view of result_unloader_if (result,
//                          result_valid, out_ack, ovf_clr in; out_pins,
//                          out_valid, busy, done, overflow out)
//  Revision    : 1.0 - initial release
// ============================================================================
module result_unloader #(
    parameter int NUM_BYTES   = 4,
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    result_unloader_if.slave   bus_if
);
    localparam int RESULT_W = 8 * NUM_BYTES;
    localparam int CNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [RESULT_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   done_q,  done_d;
    logic                   ovf_q,   ovf_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   busy;

    // out_ack comes from another clock domain; only the last stage is used.
    assign ack_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus_if.out_ack};
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                // IDLE also covers the done cycle, so a result arriving
                // there is taken without any extra gap.
                if (bus_if.result_valid) begin
                    shift_d = bus_if.result;
                    cnt_d   = CNT_W'(NUM_BYTES - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (ack_s) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!ack_s) begin
                    if (cnt_q != '0) begin
                        // Next byte lands on the pins while out_valid is
                        // low; SETUP then gives the host a stable cycle.
                        shift_d = shift_q << 8;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        // Shift register is left alone so the last byte
                        // stays visible until the next capture.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Setting has priority over clearing so a lost result is never
        // hidden by a coincident clear.
        if (bus_if.result_valid && busy) begin
            ovf_d = 1'b1;
        end else if (bus_if.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    assign bus_if.out_pins  = shift_q[RESULT_W-1 -: 8];
    assign bus_if.out_valid = (state_q == ST_WAIT_HI);
    assign bus_if.busy      = busy;
    assign bus_if.done      = done_q;
    assign bus_if.overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_result_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_unloader
//  Description : Self-checking bench for result_unloader. A behavioural model
//                tracks the byte stream, busy/done timing and the overflow
//                flag from the handshake rules; directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_unloader;
    localparam int NUM_BYTES   = 4;
    localparam int SYNC_STAGES = 2;
    localparam int RESULT_W    = 8 * NUM_BYTES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_unloader_if #(.NUM_BYTES(NUM_BYTES)) bus ();

    result_unloader #(
        .NUM_BYTES   (NUM_BYTES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model, evaluated mid-cycle (inputs are driven just after
    // the rising edge, so they are stable here).
    // ------------------------------------------------------------------
    logic [7:0] m_bytes[$];
    int         m_acks;
    int         m_cd;
    int         m_idx;
    logic       e_busy, e_done, e_ovf;
    logic       n_busy, n_done, n_ovf;
    logic       prev_ack, prev_valid, last_fall;
    logic [7:0] prev_pins;
    logic [RESULT_W-1:0] m_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_bytes.delete();
            m_acks     = 0;
            m_cd       = 0;
            e_busy     = 1'b0;
            e_done     = 1'b0;
            e_ovf      = 1'b0;
            prev_ack   = 1'b0;
            prev_valid = 1'b0;
            prev_pins  = 8'h00;
        end else begin
            last_fall = 1'b0;
            if (bus.out_ack && !prev_ack && e_busy) m_acks++;
            if (!bus.out_ack && prev_ack && e_busy && m_acks == NUM_BYTES) last_fall = 1'b1;
            prev_ack = bus.out_ack;

            check("busy", bus.busy, e_busy);
            check("done", bus.done, e_done);
            check("overflow", bus.overflow, e_ovf);
            if (!e_busy) check("valid_when_idle", bus.out_valid, 1'b0);
            if (bus.out_valid) begin
                m_idx = bus.out_ack ? m_acks - 1 : m_acks;
                if (m_idx < 0 || m_idx >= m_bytes.size())
                    check("byte_index", m_idx, m_bytes.size());
                else
                    check("pins", bus.out_pins, m_bytes[m_idx]);
                if (prev_valid) check("pins_stable", bus.out_pins, prev_pins);
            end
            prev_valid = bus.out_valid;
            prev_pins  = bus.out_pins;

            // Predict the cycle after the coming edge. The final done lands
            // SYNC_STAGES+1 edges after the host releases the last ack.
            n_busy = e_busy;
            n_done = 1'b0;
            if (m_cd > 0) begin
                if (m_cd == 1) begin
                    n_done = 1'b1;
                    n_busy = 1'b0;
                end
                m_cd--;
            end
            if (last_fall) m_cd = SYNC_STAGES;
            if (bus.result_valid && !e_busy) begin
                n_busy = 1'b1;
                m_word = bus.result;
                m_bytes.delete();
                for (int i = 0; i < NUM_BYTES; i++)
                    m_bytes.push_back(m_word[RESULT_W-1-8*i -: 8]);
                m_acks = 0;
            end
            if (bus.result_valid && e_busy) n_ovf = 1'b1;
            else if (bus.ovf_clr)           n_ovf = 1'b0;
            else                            n_ovf = e_ovf;
            e_busy = n_busy;
            e_done = n_done;
            e_ovf  = n_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Host / core helpers
    // ------------------------------------------------------------------
    logic [7:0] rx[$];

    task automatic send(input logic [RESULT_W-1:0] w);
        @(posedge clk); #1;
        bus.result       = w;
        bus.result_valid = 1'b1;
        @(posedge clk); #1;
        bus.result_valid = 1'b0;
    endtask

    task automatic wait_valid(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.out_valid === lvl) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        fail_now("wait_out_valid");
    endtask

    task automatic host_word(input int nb, input int ack_dly, input int rel_dly);
        bit ok;
        for (int b = 0; b < nb; b++) begin
            wait_valid(1'b1, ok);
            if (!ok) return;
            repeat (ack_dly) @(posedge clk);
            #1;
            check("valid_held", bus.out_valid, 1'b1);
            rx.push_back(bus.out_pins);
            bus.out_ack = 1'b1;
            wait_valid(1'b0, ok);
            if (!ok) return;
            repeat (rel_dly) @(posedge clk);
            #1;
            bus.out_ack = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                check("busy_on_done", bus.busy, 1'b0);
                return;
            end
        end
        fail_now("wait_done");
    endtask

    task automatic check_rx(input string nm, input logic [31:0] w);
        check({nm, "_count"}, rx.size(), NUM_BYTES);
        for (int i = 0; i < NUM_BYTES && i < rx.size(); i++)
            check(nm, rx[i], w[31-8*i -: 8]);
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, "_pins"},  bus.out_pins,  8'h00);
        check({nm, "_valid"}, bus.out_valid, 1'b0);
        check({nm, "_busy"},  bus.busy,      1'b0);
        check({nm, "_done"},  bus.done,      1'b0);
        check({nm, "_ovf"},   bus.overflow,  1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.result       = '0;
        bus.result_valid = 1'b0;
        bus.out_ack      = 1'b0;
        bus.ovf_clr      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic word with first-valid latency
        rx.delete();
        send(32'h12345678);
        check("setup_busy",  bus.busy,      1'b1);
        check("setup_valid", bus.out_valid, 1'b0);
        check("setup_pins",  bus.out_pins,  8'h12);
        @(posedge clk); #1;
        check("first_valid", bus.out_valid, 1'b1);
        host_word(NUM_BYTES, 3, 3);
        wait_done();
        check_rx("basic", 32'h12345678);
        check("pins_hold_last", bus.out_pins, 8'h78);

        // Negative value
        rx.delete();
        send(-32'sd5);
        host_word(NUM_BYTES, 2, 1);
        wait_done();
        check_rx("negative", 32'hFFFFFFFB);
        check("neg_ovf", bus.overflow, 1'b0);

        // Overflow while busy, clear losing against a coincident set
        rx.delete();
        send(32'h000000AA);
        fork
            host_word(NUM_BYTES, 3, 3);
            begin
                for (int i = 0; i < 2000 && rx.size() < 1; i++) @(posedge clk);
                @(posedge clk); #1;
                if (rx.size() < 1) fail_now("ovf_wait_byte");
                bus.result       = 32'h55555555;
                bus.result_valid = 1'b1;
                @(posedge clk); #1;
                bus.result_valid = 1'b0;
                @(posedge clk); #1;
                check("ovf_set", bus.overflow, 1'b1);
                bus.result       = 32'h77777777;
                bus.result_valid = 1'b1;
                bus.ovf_clr      = 1'b1;
                @(posedge clk); #1;
                bus.result_valid = 1'b0;
                bus.ovf_clr      = 1'b0;
                check("ovf_set_wins", bus.overflow, 1'b1);
            end
        join
        wait_done();
        check_rx("ovf_word", 32'h000000AA);
        check("ovf_sticky", bus.overflow, 1'b1);
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", bus.overflow, 1'b0);

        // Back-to-back: next result pulsed in the done cycle
        rx.delete();
        send(32'h0BADF00D);
        host_word(NUM_BYTES, 1, 1);
        wait_done();
        check_rx("b2b_first", 32'h0BADF00D);
        bus.result       = 32'hCAFEBABE;
        bus.result_valid = 1'b1;
        @(posedge clk); #1;
        bus.result_valid = 1'b0;
        check("b2b_busy", bus.busy, 1'b1);
        check("b2b_pins", bus.out_pins, 8'hCA);
        rx.delete();
        host_word(NUM_BYTES, 3, 3);
        wait_done();
        check_rx("b2b_second", 32'hCAFEBABE);
        check("b2b_ovf", bus.overflow, 1'b0);

        // Slow host
        rx.delete();
        send(32'h5A3C0FF1);
        host_word(NUM_BYTES, 50, 3);
        wait_done();
        check_rx("slow", 32'h5A3C0FF1);

        // Reset during WAIT_HI of byte 2
        rx.delete();
        send(32'hA1B2C3D4);
        host_word(1, 3, 3);
        begin
            bit ok;
            wait_valid(1'b1, ok);
        end
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx.delete();
        send(32'h01020304);
        check("after_reset_pins", bus.out_pins, 8'h01);
        host_word(NUM_BYTES, 3, 3);
        wait_done();
        check_rx("after_reset", 32'h01020304);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
